// File: rtl/avst_to_bt656.sv
// Avalon-ST byte stream to BT.656 4:2:2 serialiser.
// Inserts EAV/SAV codes and blanking, and flags underflow and sop/eop misalignment.
module avst_to_bt656 #(
    parameter int unsigned H_ACTIVE    = 1440,
    parameter int unsigned H_BLANK     = 268,
    parameter int unsigned LINES_TOTAL = 525,
    parameter int unsigned FIELD_LINES = 263,
    parameter int unsigned VBLANK      = 20
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] snk_data,
    input  logic       snk_valid,
    input  logic       snk_sop,
    input  logic       snk_eop,
    output logic       snk_ready,
    output logic [7:0] bt656_data,
    output logic       field,
    output logic       underflow,
    output logic       sync_error
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_BLANK + 8;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned LW      = $clog2(LINES_TOTAL);

    localparam logic [HW-1:0] SavStart = HW'(H_BLANK + 4);
    localparam logic [HW-1:0] ActStart = HW'(H_BLANK + 8);
    localparam logic [HW-1:0] HLast    = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] ActLast  = HW'(H_ACTIVE - 1);
    localparam logic [LW-1:0] LLast    = LW'(LINES_TOTAL - 1);

    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [LW-1:0] l_cnt_q, l_cnt_d;
    logic [7:0]    data_q, data_d;
    logic          field_q, underflow_q, underflow_d, sync_error_q, sync_error_d;

    logic          f_flag, v_flag, h_flag;
    logic          in_eav, in_sav, in_active;
    logic [1:0]    tc_idx;
    logic [HW-1:0] act_off;
    logic [7:0]    xy, blank_byte, clamped;

    // Line/field decode from the counters
    always_comb begin
        f_flag     = l_cnt_q >= LW'(FIELD_LINES);
        v_flag     = (l_cnt_q < LW'(VBLANK)) ||
                     (f_flag && (l_cnt_q < LW'(FIELD_LINES + VBLANK)));
        in_eav     = h_cnt_q < HW'(4);
        in_sav     = (h_cnt_q >= SavStart) && (h_cnt_q < ActStart);
        in_active  = h_cnt_q >= ActStart;
        h_flag     = in_eav;
        tc_idx     = in_eav ? h_cnt_q[1:0] : 2'(h_cnt_q - SavStart);
        act_off    = h_cnt_q - ActStart;
        xy         = {1'b1, f_flag, v_flag, h_flag, v_flag ^ h_flag, f_flag ^ h_flag,
                      f_flag ^ v_flag, f_flag ^ v_flag ^ h_flag};
        // Blanking and active regions both start on even h_cnt, so parity is h_cnt[0]
        blank_byte = h_cnt_q[0] ? 8'h10 : 8'h80;
        clamped    = (snk_data == 8'h00) ? 8'h01 :
                     (snk_data == 8'hFF) ? 8'hFE : snk_data;
        snk_ready  = in_active && !v_flag;
    end

    always_comb begin
        h_cnt_d = (h_cnt_q == HLast) ? '0 : h_cnt_q + 1'b1;
        l_cnt_d = l_cnt_q;
        if (h_cnt_q == HLast) begin
            l_cnt_d = (l_cnt_q == LLast) ? '0 : l_cnt_q + 1'b1;
        end
    end

    always_comb begin
        data_d       = blank_byte;
        underflow_d  = 1'b0;
        sync_error_d = 1'b0;
        if (in_eav || in_sav) begin
            unique case (tc_idx)
                2'd0:    data_d = 8'hFF;
                2'd3:    data_d = xy;
                default: data_d = 8'h00;
            endcase
        end else if (snk_ready) begin
            if (snk_valid) begin
                data_d       = clamped;
                sync_error_d = (snk_sop != (act_off == '0)) ||
                               (snk_eop != (act_off == ActLast));
            end else begin
                underflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            h_cnt_q      <= '0;
            l_cnt_q      <= '0;
            data_q       <= 8'h00;
            field_q      <= 1'b0;
            underflow_q  <= 1'b0;
            sync_error_q <= 1'b0;
        end else begin
            h_cnt_q      <= h_cnt_d;
            l_cnt_q      <= l_cnt_d;
            data_q       <= data_d;
            field_q      <= f_flag;
            underflow_q  <= underflow_d;
            sync_error_q <= sync_error_d;
        end
    end

    assign bt656_data = data_q;
    assign field      = field_q;
    assign underflow  = underflow_q;
    assign sync_error = sync_error_q;

endmodule

// File: doc/avst_to_bt656.md
Name: avst_to_bt656

Overview:
- Transmit-side counterpart of the BT.656 receive path: consumes an 8-bit Avalon-ST video byte stream and serialises it into a BT.656 4:2:2 byte stream.
- Inserts EAV/SAV timing codes, horizontal and vertical blanking, and F/V/H flags.
- Sits between the line-buffer FIFO read side and the video output pins; one clock domain (the pixel byte clock).

Parameters:
- H_ACTIVE, 1440, active bytes per line; even, multiple of 4.
- H_BLANK, 268, blanking bytes between end of EAV and start of SAV; even.
- LINES_TOTAL, 525, lines per frame.
- FIELD_LINES, 263, lines in field 1. F=0 for line < FIELD_LINES, else F=1.
- VBLANK, 20, blanking lines at the start of each field. V=1 there, else V=0.

Ports:
- clock  input  1  byte clock
- reset  input  1  asynchronous, active-high reset
- snk_data  input  8  Avalon-ST sink byte (Cb,Y,Cr,Y order)
- snk_valid  input  1  sink valid
- snk_sop  input  1  first byte of an active line
- snk_eop  input  1  last byte of an active line
- snk_ready  output  1  sink ready
- bt656_data  output  8  BT.656 byte stream
- field  output  1  current F flag (registered, aligned with bt656_data)
- underflow  output  1  one-cycle pulse: active slot with no valid beat
- sync_error  output  1  one-cycle pulse: sop/eop at the wrong position

Behaviour:
- Counters:
  - H_TOTAL = H_ACTIVE + H_BLANK + 8.
  - h_cnt runs 0..H_TOTAL-1 and wraps.
  - l_cnt runs 0..LINES_TOTAL-1; it increments on h_cnt wrap and wraps to 0.
- Line layout by h_cnt:
  - 0..3: EAV, H=1.
  - 4..H_BLANK+3: blanking.
  - H_BLANK+4..H_BLANK+7: SAV, H=0.
  - H_BLANK+8..H_TOTAL-1: active.
- Timing code bytes: FF, 00, 00, XY.
  - XY = {1, F, V, H, V^H, F^H, F^V, F^V^H}.
- Blanking bytes (horizontal blanking, and the active region of V=1 lines):
  - 0x80 at even offset from the region start, 0x10 at odd offset.
- snk_ready:
  - Combinational from counters.
  - 1 only when h_cnt is in the active range and V=0.
- Output path:
  - Accepted beat (snk_valid & snk_ready) at cycle t appears on bt656_data at t+1. All outputs are registered; latency is 1.
  - Active data is clamped: 0x00 becomes 0x01, 0xFF becomes 0xFE. Reserved codes never appear in the active region.
- Underflow:
  - Condition: snk_ready=1 and snk_valid=0.
  - Output the blanking pattern byte for that offset parity (0x80 even, 0x10 odd) and pulse underflow.
  - The position still advances; the missing byte is not retried.
- Sync check, on accepted beats only:
  - sop=1 at any active offset other than 0, or sop=0 at offset 0: pulse sync_error.
  - eop=1 at any active offset other than H_ACTIVE-1, or eop=0 at offset H_ACTIVE-1: pulse sync_error.
  - The data byte is still output; there is no realignment.
- Simultaneous underflow and sync error cannot occur: the sync check applies only to accepted beats.
- Reset (asynchronous):
  - h_cnt=0, l_cnt=0, bt656_data=0x00, field=0, underflow=0, sync_error=0.
  - The first edge after deassertion outputs 0xFF, the EAV of line 0.
  - Reset mid-line abandons the line. There is no partial-line flush; the upstream source must also be reset.

Test Plan:
Bench parameters: H_ACTIVE=8, H_BLANK=4, LINES_TOTAL=10, FIELD_LINES=5, VBLANK=2, so H_TOTAL=20.
- Reset release with snk_valid=0 -> line 0 bytes are FF 00 00 B6, 80 10 80 10, FF 00 00 AB, then 80 10 80 10 80 10 80 10. snk_ready=0 throughout, underflow never pulses.
- Line 2 with source bytes 10..17 (sop on the first, eop on the last) -> EAV XY=9D, SAV XY=80. snk_ready high for 8 cycles; bt656_data = 10..17 one cycle after each accept. No error pulses.
- Line 7 (field 2, active) -> EAV XY=DA, SAV XY=C7, field=1. Line 5 (field 2, blank) -> EAV XY=F1, SAV XY=EC.
- Source bytes 00 and FF in the active region -> output 01 and FE.
- snk_valid dropped at active offsets 3 and 4 -> output 10 then 80 at those slots; underflow pulses twice; the remaining bytes keep their positions.
- sop asserted at offset 2, and eop missing at offset 7 -> two sync_error pulses. Reset asserted mid-active -> bt656_data=00 immediately, and the next output after release is FF.
